// File: rtl/sdram_fb_arbiter.sv
// Arbitrates the SDRAM framebuffer bridge between fractal pixel writes and VGA scanout reads.
// Optional statistics counters are compiled in with FB_ARB_STATS_EN.
module sdram_fb_arbiter #(
    parameter int FB_WIDTH        = 640,
    parameter int FB_HEIGHT       = 480,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_RD_STREAK   = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        wr_valid,
    input  logic [9:0]  wr_x,
    input  logic [9:0]  wr_y,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        rd_valid,
    input  logic [9:0]  rd_x,
    input  logic [9:0]  rd_y,
    output logic        rd_ready,
    output logic        rd_rvalid,
    output logic [7:0]  rd_rdata,
    output logic [22:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_writedata,
    output logic [1:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [15:0] mem_readdata,
    input  logic        mem_readdatavalid,
    output logic [1:0]  dbg_state
`ifdef FB_ARB_STATS_EN
    ,
    output logic [31:0] stat_rd_cnt,
    output logic [31:0] stat_wr_cnt,
    output logic [31:0] stat_starve_cnt
`endif
);
    // Handshake: a request is taken on a cycle where valid and ready are both 1;
    // ready is never asserted without valid, and the bridge command follows one cycle later.
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(MAX_RD_STREAK + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DRAIN = 2'd3} state_t;

    state_t        state, state_next;
    logic [OW-1:0] outstanding;
    logic [OW:0]   occ;
    logic [SW-1:0] streak;
    logic          arb_en, rd_grant, wr_grant, rd_done, wr_done, rsp_take;
    logic          wr_oob, streak_block;
    logic [9:0]    rd_xc, rd_yc;
    logic [22:0]   rd_addr, wr_addr;
    logic          unused_readdata_hi;

    assign unused_readdata_hi = ^mem_readdata[15:8];

    assign rd_done  = (state == RD) && !mem_waitrequest;
    assign wr_done  = (state == WR) && !mem_waitrequest;
    assign rsp_take = mem_readdatavalid && (outstanding != '0);
    // A read completing this cycle already occupies a bridge slot.
    assign occ      = {1'b0, outstanding} + {{OW{1'b0}}, rd_done};

    assign wr_oob       = (wr_x >= 10'(FB_WIDTH)) || (wr_y >= 10'(FB_HEIGHT));
    assign streak_block = wr_valid && (streak >= SW'(MAX_RD_STREAK));
    assign rd_xc        = (rd_x >= 10'(FB_WIDTH))  ? 10'(FB_WIDTH - 1)  : rd_x;
    assign rd_yc        = (rd_y >= 10'(FB_HEIGHT)) ? 10'(FB_HEIGHT - 1) : rd_y;
    assign rd_addr      = 23'(rd_xc) * 23'(FB_HEIGHT) + 23'(rd_yc);
    assign wr_addr      = 23'(wr_x) * 23'(FB_HEIGHT) + 23'(wr_y);

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd_grant   = 1'b0;
        wr_grant   = 1'b0;
        case (state)
            IDLE:    arb_en = 1'b1;
            RD:      arb_en = !mem_waitrequest;
            WR:      arb_en = !mem_waitrequest;
            DRAIN:   arb_en = (outstanding == '0);
            default: arb_en = 1'b1;
        endcase
        if (arb_en && !RESET) begin
            if (rd_valid && (occ < (OW+1)'(MAX_OUTSTANDING)) && !streak_block) begin
                rd_grant   = 1'b1;
                state_next = RD;
            end else if (wr_valid) begin
                if (wr_oob) begin
                    wr_grant   = 1'b1;
                    state_next = IDLE;
                end else if (occ != '0) begin
                    state_next = DRAIN;
                end else begin
                    wr_grant   = 1'b1;
                    state_next = WR;
                end
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_comb begin
        mem_read       = (state == RD);
        mem_write      = (state == WR);
        mem_byteenable = (state == WR) ? 2'b01 : 2'b11;
        rd_ready       = rd_grant;
        wr_ready       = wr_grant;
        dbg_state      = state;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            outstanding   <= '0;
            streak        <= '0;
            mem_address   <= '0;
            mem_writedata <= '0;
            rd_rvalid     <= 1'b0;
            rd_rdata      <= '0;
        end else begin
            if (rd_grant)
                mem_address <= rd_addr;
            else if (wr_grant && !wr_oob)
                mem_address <= wr_addr;
            if (wr_grant && !wr_oob)
                mem_writedata <= {8'h00, wr_data};
            if (rd_done && !rsp_take)
                outstanding <= outstanding + 1'b1;
            else if (!rd_done && rsp_take)
                outstanding <= outstanding - 1'b1;
            if (!wr_valid || wr_grant)
                streak <= '0;
            else if (rd_grant && (streak < SW'(MAX_RD_STREAK)))
                streak <= streak + 1'b1;
            // Gating on outstanding drops responses to reads that a reset abandoned.
            rd_rvalid <= rsp_take;
            rd_rdata  <= mem_readdata[7:0];
        end
    end

`ifdef FB_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stat_rd_cnt     <= '0;
            stat_wr_cnt     <= '0;
            stat_starve_cnt <= '0;
        end else begin
            if (rd_done && (stat_rd_cnt != 32'hFFFF_FFFF))
                stat_rd_cnt <= stat_rd_cnt + 1'b1;
            if (wr_done && (stat_wr_cnt != 32'hFFFF_FFFF))
                stat_wr_cnt <= stat_wr_cnt + 1'b1;
            if (wr_valid && !wr_grant && (stat_starve_cnt != 32'hFFFF_FFFF))
                stat_starve_cnt <= stat_starve_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: doc/sdram_fb_arbiter.md
Name: sdram_fb_arbiter

Overview:
Shares the single SDRAM framebuffer bridge between two requesters: the fractal calculator, which writes per-pixel iteration intensity, and VGA scanout, which reads pixel intensity for the bitmap display mode. The block computes linear addresses, sequences pipelined reads and single writes with a read-over-write priority and an anti-starvation rule, and returns read data in order. It sits between fractal_calc/vga_interface and the SDRAM Avalon bridge.

Parameters:
FB_WIDTH, 640, pixel columns; x range 0..FB_WIDTH-1
FB_HEIGHT, 480, pixel rows; also the address column stride
MAX_OUTSTANDING, 4, maximum reads in flight on the bridge
MAX_RD_STREAK, 16, consecutive read grants allowed while a write waits

Ports:
CLK  in  1  system clock (50 MHz)
RESET  in  1  synchronous, active-high reset
wr_valid  in  1  fractal write request
wr_x  in  10  write column
wr_y  in  10  write row
wr_data  in  8  intensity to store
wr_ready  out  1  write accepted this cycle when wr_valid=1
rd_valid  in  1  scanout read request
rd_x  in  10  read column
rd_y  in  10  read row
rd_ready  out  1  read accepted this cycle when rd_valid=1
rd_rvalid  out  1  read data valid, one pulse per accepted read
rd_rdata  out  8  read intensity
mem_address  out  23  bridge address = x*FB_HEIGHT + y
mem_read  out  1  bridge read
mem_write  out  1  bridge write
mem_writedata  out  16  {8'h00, wr_data}
mem_byteenable  out  2  fixed 2'b01 for writes, 2'b11 for reads
mem_waitrequest  in  1  bridge stall
mem_readdata  in  16  bridge read data
mem_readdatavalid  in  1  bridge read data strobe

Behaviour:
- Reset: state IDLE; outstanding=0; streak=0; wr_ready, rd_ready, rd_rvalid, mem_read, mem_write = 0; mem_address and mem_writedata = 0.
- States: IDLE, RD (mem_read held), WR (mem_write held), DRAIN (wait for outstanding==0 before a write).
- The request is accepted (rd_ready/wr_ready pulse) on the cycle it is registered into RD/WR. Address and data are registered, so the bridge command appears one cycle after acceptance.
- Commands are held stable while mem_waitrequest=1 and complete on the first cycle with mem_waitrequest=0.
- Arbitration, evaluated in IDLE and on completion of each command:
  - A read wins if rd_valid=1, outstanding<MAX_OUTSTANDING, and not (wr_valid=1 and streak>=MAX_RD_STREAK).
  - Otherwise, if wr_valid=1: go to DRAIN when outstanding>0, else WR.
  - Otherwise go to IDLE.
- Back-to-back reads issue without an IDLE bubble.
- outstanding increments on read completion and decrements on mem_readdatavalid. A simultaneous increment and decrement leaves it unchanged. Reads are never issued with outstanding=MAX_OUTSTANDING.
- streak increments per read grant while wr_valid=1. It clears on a write grant or whenever wr_valid=0.
- rd_rvalid = mem_readdatavalid registered one cycle; rd_rdata = mem_readdata[7:0]. Data is returned in issue order, because the bridge returns in order.
- Address arithmetic: 10-bit x times constant FB_HEIGHT, plus y, zero-extended to 23 bits.
- Out-of-range write (x>=FB_WIDTH or y>=FB_HEIGHT): accepted with wr_ready, no bridge command issued, streak cleared.
- Out-of-range read: coordinates clamped to FB_WIDTH-1 / FB_HEIGHT-1; the read is issued normally, so response count always equals accept count.
- Simultaneous rd_valid and wr_valid with streak below the limit: the read wins.
- RESET mid-command: the command drops immediately and outstanding clears. Bridge responses arriving after reset are ignored, because rd_rvalid is gated by outstanding>0.

Optional Feature:
FB_ARB_STATS_EN: when defined, adds three output ports:
- stat_rd_cnt (32): completed reads.
- stat_wr_cnt (32): completed writes.
- stat_starve_cnt (32): cycles with wr_valid=1 and wr_ready=0.

All three clear on RESET and saturate at 32'hFFFFFFFF. When undefined, the ports and counters are absent and arbitration behaviour is identical.

Test Plan:
- Single write x=3, y=5, data=8'hA7, waitrequest=0 → mem_write=1 one cycle, mem_address=1445, mem_writedata=16'h00A7, mem_byteenable=2'b01.
- Eight reads back-to-back, bridge latency 3 cycles → at most 4 outstanding, rd_rvalid pulses 8 times in issue order, rd_rdata matches mem_readdata[7:0].
- Continuous rd_valid with wr_valid=1 held → exactly one write granted after every 16 read grants; the state passes through DRAIN until outstanding=0 before each write.
- mem_waitrequest=1 for 5 cycles during a write → mem_address and mem_writedata stable throughout, wr_ready not re-asserted until completion.
- Write x=640, y=0 → wr_ready=1, no mem_write. Read x=700, y=500 → mem_address=639*480+479=307199.
- RESET asserted with 2 reads outstanding, then a late mem_readdatavalid → no rd_rvalid. With FB_ARB_STATS_EN defined, all counters read 0 after reset.
